// File: rtl/mem_stage_sram_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_sram_ctrl
//
// MEM stage of the pipeline. Consumes the EXE/MEM register outputs, performs
// the data-memory access on an external 16-bit asynchronous SRAM (two
// half-word phases per 32-bit word, each phase WAIT_CYCLES+1 cycles long),
// stalls upstream through `ready` while the access is in flight, and holds
// the MEM/WB pipeline register that feeds writeback.
//
// Parameters
//   ADDR_BASE   byte address of data-memory word 0 (subtracted from alu_res_in)
//   SRAM_AW     SRAM half-word address width
//   WAIT_CYCLES extra cycles per half-word phase (0..3)
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   wb_en_in              writeback enable from EXE/MEM
//   mem_read_en_in        load request
//   mem_write_en_in       store request (wins when both requests are set)
//   alu_res_in            ALU result / byte address
//   val_Rm_in             store data
//   dest_in               destination register
//   ready                 1 = pipeline may advance, 0 = freeze upstream
//   wb_en, mem_read_en,
//   dest, alu_res,
//   mem_data              MEM/WB register outputs
//   sram_addr             SRAM half-word address
//   sram_dq_out           write data to SRAM
//   sram_dq_in            read data from SRAM
//   sram_dq_oe            1 = drive DQ (writes)
//   sram_we_n             SRAM write strobe, active low
// -----------------------------------------------------------------------------
module mem_stage_sram_ctrl #(
  parameter int ADDR_BASE   = 1024,
  parameter int SRAM_AW     = 18,
  parameter int WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wb_en_in,
  input  logic               mem_read_en_in,
  input  logic               mem_write_en_in,
  input  logic [31:0]        alu_res_in,
  input  logic [31:0]        val_Rm_in,
  input  logic [3:0]         dest_in,
  output logic               ready,
  output logic               wb_en,
  output logic               mem_read_en,
  output logic [3:0]         dest,
  output logic [31:0]        alu_res,
  output logic [31:0]        mem_data,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] WAIT_LAST = 2'(WAIT_CYCLES);

  state_t             state;
  state_t             state_nxt;
  logic [1:0]         wait_cnt;
  logic               phase_last;
  logic               req;

  // Latched request (captured in IDLE, used for the whole access)
  logic [SRAM_AW-2:0] word_p0;
  logic [31:0]        data_p0;
  logic [3:0]         dest_p0;
  logic [31:0]        alu_p0;
  logic               wr_p0;
  logic               rd_p0;
  logic               wb_p0;

  // Read buffer halves
  logic [15:0]        lo_p1;
  logic [15:0]        hi_p1;

  // Word index into the SRAM: byte offset from ADDR_BASE (wrapping modulo
  // 2^32), byte lane bits dropped, truncated to the half-word address space.
  function automatic logic [SRAM_AW-2:0] word_addr(input logic [31:0] byte_addr);
    return (SRAM_AW-1)'((byte_addr - 32'(ADDR_BASE)) >> 2);
  endfunction

  assign req        = mem_read_en_in | mem_write_en_in;
  assign phase_last = (wait_cnt == WAIT_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req)        state_nxt = LO;
      LO:      if (phase_last) state_nxt = HI;
      HI:      if (phase_last) state_nxt = DONE;
      DONE:                    state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Output logic: SRAM pins and stall
  always_comb begin
    ready       = 1'b0;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    case (state)
      IDLE: ready = ~req;
      LO: begin
        sram_addr = {word_p0, 1'b0};
        if (wr_p0) begin
          sram_dq_out = data_p0[15:0];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
      end
      HI: begin
        sram_addr = {word_p0, 1'b1};
        if (wr_p0) begin
          sram_dq_out = data_p0[31:16];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
      end
      DONE: ready = 1'b1;
      default: ready = 1'b1;
    endcase
    // Upstream must not see a stall while the block is held in reset, even
    // if request inputs are still asserted.
    if (rst) begin
      ready = 1'b1;
    end
  end

  // Phase wait counter: restarts at every phase entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 2'd0;
    end else if ((state == LO || state == HI) && !phase_last) begin
      wait_cnt <= wait_cnt + 2'd1;
    end else begin
      wait_cnt <= 2'd0;
    end
  end

  // ---- Stage p0: request capture -------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_p0 <= 1'b0;
      rd_p0 <= 1'b0;
      wb_p0 <= 1'b0;
    end else if (state == IDLE && req) begin
      wr_p0 <= mem_write_en_in;
      // A simultaneous read and write is executed as a write only.
      rd_p0 <= mem_read_en_in & ~mem_write_en_in;
      wb_p0 <= wb_en_in;
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      word_p0 <= word_addr(alu_res_in);
      data_p0 <= val_Rm_in;
      dest_p0 <= dest_in;
      alu_p0  <= alu_res_in;
    end
  end

  // ---- Stage p1: SRAM read sampling on the last cycle of each phase ---------
  always_ff @(posedge clk) begin
    if (rd_p0 && phase_last) begin
      if (state == LO) begin
        lo_p1 <= sram_dq_in;
      end
      if (state == HI) begin
        hi_p1 <= sram_dq_in;
      end
    end
  end

  // ---- Stage p2: MEM/WB register --------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en       <= 1'b0;
      mem_read_en <= 1'b0;
      dest        <= 4'd0;
      alu_res     <= 32'd0;
      mem_data    <= 32'd0;
    end else if (state == IDLE && !req) begin
      // Non-memory pass-through; no request means the load flag is 0.
      wb_en       <= wb_en_in;
      mem_read_en <= 1'b0;
      dest        <= dest_in;
      alu_res     <= alu_res_in;
    end else if (state == DONE) begin
      wb_en       <= wb_p0;
      mem_read_en <= rd_p0;
      dest        <= dest_p0;
      alu_res     <= alu_p0;
      if (rd_p0) begin
        mem_data <= {hi_p1, lo_p1};
      end
    end else begin
      // Stall bubble: upstream is frozen, so suppress a duplicate writeback.
      wb_en       <= 1'b0;
      mem_read_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
module tb_mem_stage_sram_ctrl;

  localparam int BASE = 1024;
  localparam int AW   = 18;
  localparam int W1   = 1;
  localparam int W0   = 0;

  logic clk = 1'b0;
  logic rst;

  // DUT with WAIT_CYCLES=1
  logic          wb_en_in, rd_in, wr_in;
  logic [31:0]   alu_in, rm_in;
  logic [3:0]    dest_in;
  logic          ready, wb_en, mem_read_en;
  logic [3:0]    dest;
  logic [31:0]   alu_res, mem_data;
  logic [AW-1:0] sram_addr;
  logic [15:0]   dq_out, dq_in;
  logic          dq_oe, we_n;

  // DUT with WAIT_CYCLES=0
  logic          z_wb_en_in, z_rd_in, z_wr_in;
  logic [31:0]   z_alu_in, z_rm_in;
  logic [3:0]    z_dest_in;
  logic          z_ready, z_wb_en, z_mem_read_en;
  logic [3:0]    z_dest;
  logic [31:0]   z_alu_res, z_mem_data;
  logic [AW-1:0] z_sram_addr;
  logic [15:0]   z_dq_out, z_dq_in;
  logic          z_dq_oe, z_we_n;

  // SRAM models (10-bit physical, upper address bits alias) and reference images
  logic [15:0] sram1 [0:1023];
  logic [15:0] ref1  [0:1023];
  logic [15:0] sram0 [0:1023];
  logic [15:0] ref0  [0:1023];

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model_md;

  assign dq_in   = sram1[sram_addr[9:0]];
  assign z_dq_in = sram0[z_sram_addr[9:0]];

  always #5 clk = ~clk;

  mem_stage_sram_ctrl #(.ADDR_BASE(BASE), .SRAM_AW(AW), .WAIT_CYCLES(W1)) dut1 (
    .clk(clk), .rst(rst),
    .wb_en_in(wb_en_in), .mem_read_en_in(rd_in), .mem_write_en_in(wr_in),
    .alu_res_in(alu_in), .val_Rm_in(rm_in), .dest_in(dest_in),
    .ready(ready), .wb_en(wb_en), .mem_read_en(mem_read_en), .dest(dest),
    .alu_res(alu_res), .mem_data(mem_data),
    .sram_addr(sram_addr), .sram_dq_out(dq_out), .sram_dq_in(dq_in),
    .sram_dq_oe(dq_oe), .sram_we_n(we_n)
  );

  mem_stage_sram_ctrl #(.ADDR_BASE(BASE), .SRAM_AW(AW), .WAIT_CYCLES(W0)) dut0 (
    .clk(clk), .rst(rst),
    .wb_en_in(z_wb_en_in), .mem_read_en_in(z_rd_in), .mem_write_en_in(z_wr_in),
    .alu_res_in(z_alu_in), .val_Rm_in(z_rm_in), .dest_in(z_dest_in),
    .ready(z_ready), .wb_en(z_wb_en), .mem_read_en(z_mem_read_en), .dest(z_dest),
    .alu_res(z_alu_res), .mem_data(z_mem_data),
    .sram_addr(z_sram_addr), .sram_dq_out(z_dq_out), .sram_dq_in(z_dq_in),
    .sram_dq_oe(z_dq_oe), .sram_we_n(z_we_n)
  );

  // Word index as the address rule defines it
  function automatic logic [AW-2:0] word_of(input logic [31:0] a);
    return (AW-1)'((a - 32'(BASE)) >> 2);
  endfunction

  // One memory instruction on dut1, from the IDLE request cycle through capture.
  task automatic run_mem(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] dst, input logic wb);
    logic [AW-2:0] w;
    logic [AW-1:0] exp_addr;
    logic          in_lo, in_hi, exp_we_n;
    int            n, lo_i, hi_i;
    w    = word_of(a);
    n    = 2 * (W1 + 1);
    lo_i = (int'(w) * 2) % 1024;
    hi_i = lo_i + 1;
    rd_in = rd; wr_in = wr; alu_in = a; rm_in = d; dest_in = dst; wb_en_in = wb;
    for (int k = 0; k <= n + 1; k++) begin
      @(negedge clk);
      in_lo    = (k >= 1) && (k <= W1 + 1);
      in_hi    = (k > W1 + 1) && (k <= n);
      exp_addr = in_lo ? {w, 1'b0} : (in_hi ? {w, 1'b1} : '0);
      exp_we_n = !(wr && (in_lo || in_hi));
      n_checks++;
      if (ready !== (k == n + 1)) begin
        n_fail++; $display("FAIL ready cyc%0d: got %b want %b", k, ready, (k == n + 1));
      end
      if (k >= 1) begin
        n_checks++;
        if ({wb_en, mem_read_en} !== 2'b00) begin
          n_fail++; $display("FAIL stall_bubble cyc%0d: got %b want 00", k, {wb_en, mem_read_en});
        end
      end
      n_checks++;
      if (sram_addr !== exp_addr) begin
        n_fail++; $display("FAIL sram_addr cyc%0d: got %h want %h", k, sram_addr, exp_addr);
      end
      n_checks++;
      if ({we_n, dq_oe} !== {exp_we_n, !exp_we_n}) begin
        n_fail++; $display("FAIL we_oe cyc%0d: got %b want %b", k, {we_n, dq_oe}, {exp_we_n, !exp_we_n});
      end
      if (!exp_we_n) begin
        n_checks++;
        if (dq_out !== (in_lo ? d[15:0] : d[31:16])) begin
          n_fail++; $display("FAIL dq_out cyc%0d: got %h want %h", k, dq_out, in_lo ? d[15:0] : d[31:16]);
        end
      end
      if (!we_n) sram1[sram_addr[9:0]] = dq_out;
      @(posedge clk); #1;
    end
    rd_in = 1'b0; wr_in = 1'b0; wb_en_in = 1'b0;
    if (rd && !wr) model_md = {ref1[hi_i], ref1[lo_i]};
    if (wr) begin
      ref1[lo_i] = d[15:0];
      ref1[hi_i] = d[31:16];
      n_checks++;
      if ({sram1[hi_i], sram1[lo_i]} !== d) begin
        n_fail++; $display("FAIL sram_written: got %h want %h", {sram1[hi_i], sram1[lo_i]}, d);
      end
    end
    n_checks++;
    if ({wb_en, mem_read_en} !== {wb, rd & ~wr}) begin
      n_fail++; $display("FAIL memwb_flags: got %b want %b", {wb_en, mem_read_en}, {wb, rd & ~wr});
    end
    n_checks++;
    if (dest !== dst || alu_res !== a) begin
      n_fail++; $display("FAIL memwb_dest_alu: got %h/%h want %h/%h", dest, alu_res, dst, a);
    end
    n_checks++;
    if (mem_data !== model_md) begin
      n_fail++; $display("FAIL mem_data: got %h want %h", mem_data, model_md);
    end
  endtask

  // One non-memory instruction on dut1: single-cycle pass-through.
  task automatic run_nop(input logic [31:0] a, input logic [3:0] dst, input logic wb);
    rd_in = 1'b0; wr_in = 1'b0; alu_in = a; dest_in = dst; wb_en_in = wb;
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++; $display("FAIL nop_ready: got %b want 1", ready);
    end
    n_checks++;
    if ({we_n, dq_oe, sram_addr} !== {1'b1, 1'b0, {AW{1'b0}}}) begin
      n_fail++; $display("FAIL nop_pins_idle: got %b/%b/%h want 1/0/0", we_n, dq_oe, sram_addr);
    end
    @(posedge clk); #1;
    wb_en_in = 1'b0;
    n_checks++;
    if ({wb_en, mem_read_en, dest, alu_res} !== {wb, 1'b0, dst, a}) begin
      n_fail++; $display("FAIL nop_memwb: got %b %b %h %h want %b 0 %h %h", wb_en, mem_read_en, dest, alu_res, wb, dst, a);
    end
    n_checks++;
    if (mem_data !== model_md) begin
      n_fail++; $display("FAIL nop_mem_data: got %h want %h", mem_data, model_md);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({ready, wb_en, mem_read_en, dest, alu_res, mem_data} !== {1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0}) begin
      n_fail++; $display("FAIL reset_outputs: got %b %b %b %h %h %h want 1 0 0 0 0 0", ready, wb_en, mem_read_en, dest, alu_res, mem_data);
    end
    n_checks++;
    if ({we_n, dq_oe, sram_addr, dq_out} !== {1'b1, 1'b0, {AW{1'b0}}, 16'd0}) begin
      n_fail++; $display("FAIL reset_pins: got %b %b %h %h want 1 0 0 0", we_n, dq_oe, sram_addr, dq_out);
    end
    n_checks++;
    if ({z_ready, z_wb_en} !== 2'b10) begin
      n_fail++; $display("FAIL reset_dut0: got %b want 10", {z_ready, z_wb_en});
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    model_md = 32'd0;
  endtask

  task automatic test_nonmem();
    run_nop(32'd7, 4'd3, 1'b1);
  endtask

  task automatic test_store();
    run_mem(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 4'd5, 1'b0);
  endtask

  task automatic test_load();
    sram1[4] = 16'h5678; ref1[4] = 16'h5678;
    sram1[5] = 16'h1234; ref1[5] = 16'h1234;
    run_mem(1'b1, 1'b0, 32'd1032, 32'd0, 4'd9, 1'b1);
    n_checks++;
    if (mem_data !== 32'h12345678) begin
      n_fail++; $display("FAIL load_1032: got %h want 12345678", mem_data);
    end
  endtask

  task automatic test_rw_both();
    run_mem(1'b1, 1'b1, 32'd1024, 32'hCAFEF00D, 4'd2, 1'b1);
  endtask

  task automatic test_addr_wrap();
    // Below ADDR_BASE wraps modulo 2^32; byte-lane bits are ignored.
    run_mem(1'b1, 1'b0, 32'd1020, 32'd0, 4'd1, 1'b1);
    run_mem(1'b0, 1'b1, 32'd1043, 32'h0BADF00D, 4'd4, 1'b1);
    run_mem(1'b1, 1'b0, 32'd1040, 32'd0, 4'd6, 1'b1);
  endtask

  task automatic test_random();
    int op;
    logic [31:0] a;
    for (int i = 0; i < 25; i++) begin
      op = $urandom_range(0, 3);
      a  = 32'(BASE) + 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(0, 3));
      case (op)
        0: run_nop($urandom, 4'($urandom), 1'($urandom));
        1: run_mem(1'b1, 1'b0, a, 32'd0, 4'($urandom), 1'($urandom));
        2: run_mem(1'b0, 1'b1, a, $urandom, 4'($urandom), 1'($urandom));
        default: run_mem(1'b1, 1'b1, a, $urandom, 4'($urandom), 1'($urandom));
      endcase
    end
  endtask

  task automatic test_reset_mid_write();
    rd_in = 1'b0; wr_in = 1'b1; alu_in = 32'd1064; rm_in = 32'h55AA33CC; dest_in = 4'd7; wb_en_in = 1'b1;
    repeat (W1 + 2) @(posedge clk);
    #3;
    n_checks++;
    if ({we_n, dq_oe, dq_out} !== {1'b0, 1'b1, 16'h55AA}) begin
      n_fail++; $display("FAIL hi_phase_before_reset: got %b %b %h want 0 1 55aa", we_n, dq_oe, dq_out);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({we_n, dq_oe, ready} !== 3'b101) begin
      n_fail++; $display("FAIL reset_mid_pins: got %b want 101", {we_n, dq_oe, ready});
    end
    n_checks++;
    if ({wb_en, mem_read_en, dest, alu_res, mem_data, sram_addr} !== '0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got %b %b %h %h %h %h want all 0", wb_en, mem_read_en, dest, alu_res, mem_data, sram_addr);
    end
    wr_in = 1'b0; wb_en_in = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    model_md = 32'd0;
    run_nop(32'h0000ABCD, 4'd11, 1'b1);
  endtask

  task automatic test_back_to_back();
    int pulses;
    logic [AW-2:0] w;
    logic [31:0] a;
    logic [3:0]  dst;
    int lo_i;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      a   = 32'(BASE) + 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(0, 3));
      dst = 4'($urandom);
      w   = word_of(a);
      lo_i = (int'(w) * 2) % 1024;
      z_rd_in = 1'b1; z_wr_in = 1'b0; z_alu_in = a; z_rm_in = $urandom; z_dest_in = dst; z_wb_en_in = 1'b1;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        n_checks++;
        if (z_ready !== (k == 3)) begin
          n_fail++; $display("FAIL b2b_ready ld%0d cyc%0d: got %b want %b", i, k, z_ready, (k == 3));
        end
        n_checks++;
        if ({z_we_n, z_dq_oe, z_dq_out} !== {1'b1, 1'b0, 16'd0}) begin
          n_fail++; $display("FAIL b2b_pins ld%0d cyc%0d: got %b %b %h", i, k, z_we_n, z_dq_oe, z_dq_out);
        end
        if (z_wb_en) pulses++;
        @(posedge clk); #1;
      end
      n_checks++;
      if ({z_mem_data, z_dest, z_alu_res, z_mem_read_en} !== {ref0[lo_i + 1], ref0[lo_i], dst, a, 1'b1}) begin
        n_fail++; $display("FAIL b2b_load ld%0d: got %h %h %h %b want %h %h %h 1", i, z_mem_data, z_dest, z_alu_res, z_mem_read_en, {ref0[lo_i + 1], ref0[lo_i]}, dst, a);
      end
    end
    z_rd_in = 1'b0; z_wb_en_in = 1'b0;
    @(negedge clk);
    if (z_wb_en) pulses++;
    n_checks++;
    if (pulses !== 6) begin
      n_fail++; $display("FAIL b2b_wb_pulses: got %0d want 6", pulses);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    wb_en_in = 1'b0; rd_in = 1'b0; wr_in = 1'b0; alu_in = '0; rm_in = '0; dest_in = '0;
    z_wb_en_in = 1'b0; z_rd_in = 1'b0; z_wr_in = 1'b0; z_alu_in = '0; z_rm_in = '0; z_dest_in = '0;
    model_md = 32'd0;
    for (int i = 0; i < 1024; i++) begin
      sram1[i] = 16'($urandom); ref1[i] = sram1[i];
      sram0[i] = 16'($urandom); ref0[i] = sram0[i];
    end
    test_reset();
    test_nonmem();
    test_store();
    test_load();
    test_rw_both();
    test_addr_wrap();
    test_random();
    test_reset_mid_write();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
